// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause/[mtval] through the CSR write port,
// reads mtvec (trap) or mepc (MRET) and redirects fetch. Optional mtval save: TRAP_TVAL_EN.
module trap_ctrl #(
    parameter logic [4:0] MEPC_IDX   = 5'd1,
    parameter logic [4:0] MCAUSE_IDX = 5'd2,
    parameter logic [4:0] MTVAL_IDX  = 5'd3,
    parameter logic [4:0] MTVEC_IDX  = 5'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        irq,
    input  logic [31:0] irq_pc,
    input  logic        mret_valid,
    input  logic        mie_wr_en,
    input  logic        mie_wr_val,
    input  logic [31:0] csr_rdata,
    output logic [31:0] csr_addr_o,
    output logic [2:0]  csr_func_o,
    output logic [31:0] csr_data_o,
    output logic        csr_sel_o,
    output logic        flush,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mie
);

    typedef enum logic [3:0] {
        S_IDLE, S_SAVE_EPC, S_SAVE_CAUSE, S_SAVE_TVAL, S_VEC_RD,
        S_VEC_WAIT, S_REDIRECT, S_EPC_RD, S_EPC_WAIT
    } state_t;

    state_t      state, state_next;
    logic [31:0] epc_q, cause_q, tval_q, target_q;
    logic        mie_q, mpie_q, mret_q;
    logic        idle, take_exc, take_irq, take_mret;

    // Accept priority: exception, then enabled interrupt, then MRET.
    assign idle      = (state == S_IDLE);
    assign take_exc  = idle && exc_valid;
    assign take_irq  = idle && !exc_valid && irq && mie_q;
    assign take_mret = idle && !exc_valid && !(irq && mie_q) && mret_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (take_exc || take_irq) state_next = S_SAVE_EPC;
                else if (take_mret)       state_next = S_EPC_RD;
            end
            S_SAVE_EPC:   state_next = S_SAVE_CAUSE;
`ifdef TRAP_TVAL_EN
            S_SAVE_CAUSE: state_next = S_SAVE_TVAL;
            S_SAVE_TVAL:  state_next = S_VEC_RD;
`else
            S_SAVE_CAUSE: state_next = S_VEC_RD;
`endif
            S_VEC_RD:     state_next = S_VEC_WAIT;
            S_VEC_WAIT:   state_next = S_REDIRECT;
            S_EPC_RD:     state_next = S_EPC_WAIT;
            S_EPC_WAIT:   state_next = S_REDIRECT;
            S_REDIRECT:   state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        csr_addr_o     = 32'd0;
        csr_func_o     = 3'b000;
        csr_data_o     = 32'd0;
        csr_sel_o      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (state)
            S_SAVE_EPC: begin
                csr_sel_o  = 1'b1;
                csr_func_o = 3'b001;
                csr_addr_o = {27'd0, MEPC_IDX};
                csr_data_o = epc_q;
            end
            S_SAVE_CAUSE: begin
                csr_sel_o  = 1'b1;
                csr_func_o = 3'b001;
                csr_addr_o = {27'd0, MCAUSE_IDX};
                csr_data_o = cause_q;
            end
            S_SAVE_TVAL: begin
                csr_sel_o  = 1'b1;
                csr_func_o = 3'b001;
                csr_addr_o = {27'd0, MTVAL_IDX};
                csr_data_o = tval_q;
            end
            S_VEC_RD, S_VEC_WAIT: csr_addr_o = {27'd0, MTVEC_IDX};
            S_EPC_RD, S_EPC_WAIT: csr_addr_o = {27'd0, MEPC_IDX};
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = {target_q[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign busy  = !idle;
    assign flush = !idle;
    assign mie   = mie_q;

`ifdef TRAP_TVAL_EN
    logic [31:0] tval_in;
    assign tval_in = exc_tval;
`else
    logic [31:0] tval_in;
    logic        unused_tval;
    assign tval_in     = 32'd0;
    assign unused_tval = ^exc_tval;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q    <= 32'd0;
            cause_q  <= 32'd0;
            tval_q   <= 32'd0;
            target_q <= 32'd0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mret_q   <= 1'b0;
        end else begin
            if (take_exc || take_irq) begin
                epc_q   <= take_exc ? exc_pc : irq_pc;
                cause_q <= {take_irq, 26'd0, (take_exc ? exc_cause : 5'd11)};
                tval_q  <= take_exc ? tval_in : 32'd0;
                mpie_q  <= mie_q;
                mie_q   <= 1'b0;
                mret_q  <= 1'b0;
            end else if (take_mret) begin
                mret_q <= 1'b1;
            end else if (idle && mie_wr_en) begin
                mie_q <= mie_wr_val;
            end
            // CSR read data is registered, so it is valid in the WAIT state.
            if (state == S_VEC_WAIT || state == S_EPC_WAIT) target_q <= csr_rdata;
            if (state == S_REDIRECT && mret_q) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

endmodule
